// File: rtl/ring_pkg.sv
// Shared types and helpers for the ring-stop controller.
package ring_pkg;

    // Default flit width of the ring; modules take WIDTH as a parameter.
    localparam int unsigned FLIT_W = 8;

    // Widest flit the dest_of() helper accepts.
    localparam int unsigned MAX_W = 64;

    typedef logic [FLIT_W-1:0] flit_t;

    // Out-slot arbitration mode: ring priority, or local forced after starvation.
    typedef enum logic {
        S_RING,
        S_FORCE
    } state_e;

    // Destination field is the top dst_w bits of a width-bit flit.
    function automatic logic [MAX_W-1:0] dest_of(input logic [MAX_W-1:0] flit,
                                                  input int unsigned     width,
                                                  input int unsigned     dst_w);
        logic [MAX_W-1:0] mask;
        mask = (MAX_W'(1) << dst_w) - MAX_W'(1);
        return (flit >> (width - dst_w)) & mask;
    endfunction

endpackage

// File: rtl/ring_out_slice.sv
// Single-entry valid/ready output register. Loads only when the caller sees free_o.
module ring_out_slice
    import ring_pkg::*;
#(
    parameter int unsigned WIDTH = FLIT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             rdy_i,
    output logic             vld_o,
    output logic [WIDTH-1:0] data_o,
    output logic             free_o
);

    logic             vld_q;
    logic [WIDTH-1:0] data_q;

    // Holding register: load wins, otherwise a handshake empties the slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else if (load_i) begin
            vld_q  <= 1'b1;
            data_q <= data_i;
        end else if (rdy_i) begin
            vld_q  <= 1'b0;
        end
    end

    assign vld_o  = vld_q;
    assign data_o = data_q;
    // Slot can take a new flit when empty or being drained this cycle.
    assign free_o = !vld_q | rdy_i;

endmodule

// File: rtl/ring_stop_arb.sv
// Ring-stop controller: ejects ring flits for this node and arbitrates the
// downstream link between through traffic and local injection.
module ring_stop_arb
    import ring_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DST_W      = 2,
    parameter int unsigned NODE_ID    = 0,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iRingEmpty,
    input  logic [WIDTH-1:0] iRingDat,
    output logic             oRingRdEn,
    input  logic             iLocEmpty,
    input  logic [WIDTH-1:0] iLocDat,
    output logic             oLocRdEn,
    output logic             oOutVld,
    output logic [WIDTH-1:0] oOutDat,
    input  logic             iOutRdy,
    output logic             oEjVld,
    output logic [WIDTH-1:0] oEjDat,
    input  logic             iEjRdy,
    output logic             oStarve
);

    localparam logic [DST_W-1:0] NodeAddr = DST_W'(NODE_ID);
    localparam int unsigned      CntW     = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;
    // Counter value whose next ring win trips the force.
    localparam logic [CntW-1:0]  CntLast  = CntW'(STARVE_MAX - 1);

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic [DST_W-1:0]  ring_dest;
    logic              ring_ej;
    logic              ring_fwd;
    logic              out_free;
    logic              ej_free;
    logic              ej_load;
    logic              ring_fwd_gnt;
    logic              loc_gnt;
    logic [WIDTH-1:0]  out_din;

    assign ring_dest = DST_W'(dest_of(MAX_W'(iRingDat), WIDTH, DST_W));
    assign ring_ej   = !iRingEmpty && (ring_dest == NodeAddr);
    assign ring_fwd  = !iRingEmpty && !ring_ej;

    // Eject path: a blocked eject slot stalls the ring head but not local traffic.
    assign ej_load = !rst && ring_ej && ej_free;

    // Out-slot arbitration; ring priority unless the starve FSM forces local.
    always_comb begin
        ring_fwd_gnt = 1'b0;
        loc_gnt      = 1'b0;
        if (!rst && out_free) begin
            case (state_q)
                S_FORCE: begin
                    if (!iLocEmpty) begin
                        loc_gnt = 1'b1;
                    end else if (ring_fwd) begin
                        ring_fwd_gnt = 1'b1;
                    end
                end
                default: begin
                    if (ring_fwd) begin
                        ring_fwd_gnt = 1'b1;
                    end else if (!iLocEmpty) begin
                        loc_gnt = 1'b1;
                    end
                end
            endcase
        end
    end

    assign oRingRdEn = ej_load | ring_fwd_gnt;
    assign oLocRdEn  = loc_gnt;
    assign out_din   = loc_gnt ? iLocDat : iRingDat;

    // Starvation tracking: count ring wins over a waiting local flit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (loc_gnt) begin
            state_d = S_RING;
            cnt_d   = '0;
        end else if (ring_fwd_gnt && (state_q == S_RING) && !iLocEmpty) begin
            if (cnt_q == CntLast) begin
                state_d = S_FORCE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // FSM and counter state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RING;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign oStarve = (state_q == S_FORCE);

    ring_out_slice #(
        .WIDTH (WIDTH)
    ) u_out_slice (
        .clk    (clk),
        .rst    (rst),
        .load_i (ring_fwd_gnt | loc_gnt),
        .data_i (out_din),
        .rdy_i  (iOutRdy),
        .vld_o  (oOutVld),
        .data_o (oOutDat),
        .free_o (out_free)
    );

    ring_out_slice #(
        .WIDTH (WIDTH)
    ) u_ej_slice (
        .clk    (clk),
        .rst    (rst),
        .load_i (ej_load),
        .data_i (iRingDat),
        .rdy_i  (iEjRdy),
        .vld_o  (oEjVld),
        .data_o (oEjDat),
        .free_o (ej_free)
    );

endmodule

// File: tb/tb_ring_stop_arb.sv
// Bench for ring_stop_arb with NODE_ID=3, STARVE_MAX=4.
module tb_ring_stop_arb;
    import ring_pkg::*;

    logic  clk;
    logic  rst;
    logic  iRingEmpty;
    flit_t iRingDat;
    logic  oRingRdEn;
    logic  iLocEmpty;
    flit_t iLocDat;
    logic  oLocRdEn;
    logic  oOutVld;
    flit_t oOutDat;
    logic  iOutRdy;
    logic  oEjVld;
    flit_t oEjDat;
    logic  iEjRdy;
    logic  oStarve;

    int n_cmp = 0;
    int n_err = 0;

    flit_t out_q[$];
    flit_t ej_q[$];

    typedef struct packed {
        logic  re;
        flit_t rd;
        logic  le;
        flit_t ld;
        logic  ordy;
        logic  erdy;
        logic  rr;
        logic  lr;
    } vec_t;

    vec_t tbl[13];

    ring_stop_arb #(
        .WIDTH      (8),
        .DST_W      (2),
        .NODE_ID    (3),
        .STARVE_MAX (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .iRingEmpty (iRingEmpty),
        .iRingDat   (iRingDat),
        .oRingRdEn  (oRingRdEn),
        .iLocEmpty  (iLocEmpty),
        .iLocDat    (iLocDat),
        .oLocRdEn   (oLocRdEn),
        .oOutVld    (oOutVld),
        .oOutDat    (oOutDat),
        .iOutRdy    (iOutRdy),
        .oEjVld     (oEjVld),
        .oEjDat     (oEjDat),
        .iEjRdy     (iEjRdy),
        .oStarve    (oStarve)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard side: compare each accepted output against the oldest expectation.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (oOutVld === 1'b1 && iOutRdy === 1'b1) begin
                if (out_q.size() == 0) chk("out_unexpected", 32'(oOutDat), 32'hFFFF_FFFF);
                else chk("out_dat", 32'(oOutDat), 32'(out_q.pop_front()));
            end
            if (oEjVld === 1'b1 && iEjRdy === 1'b1) begin
                if (ej_q.size() == 0) chk("ej_unexpected", 32'(oEjDat), 32'hFFFF_FFFF);
                else chk("ej_dat", 32'(oEjDat), 32'(ej_q.pop_front()));
            end
        end
    end

    // One cycle: drive inputs after the edge, record expected pops, check at negedge.
    task automatic step(input logic r, input logic re, input flit_t rd, input logic le,
                        input flit_t ld, input logic ordy, input logic erdy,
                        input logic exp_rr, input logic exp_lr, input logic exp_st);
        @(posedge clk);
        #1;
        rst        = r;
        iRingEmpty = re;
        iRingDat   = rd;
        iLocEmpty  = le;
        iLocDat    = ld;
        iOutRdy    = ordy;
        iEjRdy     = erdy;
        if (exp_rr) begin
            if (rd[7:6] == 2'd3) ej_q.push_back(rd);
            else out_q.push_back(rd);
        end
        if (exp_lr) out_q.push_back(ld);
        @(negedge clk);
        chk("ring_rden", 32'(oRingRdEn), 32'(exp_rr));
        chk("loc_rden", 32'(oLocRdEn), 32'(exp_lr));
        chk("starve", 32'(oStarve), 32'(exp_st));
    endtask

    initial begin
        rst        = 1'b1;
        iRingEmpty = 1'b0;
        iRingDat   = 8'hC1;
        iLocEmpty  = 1'b0;
        iLocDat    = 8'h11;
        iOutRdy    = 1'b1;
        iEjRdy     = 1'b1;

        //          re    rd     le    ld     ordy  erdy  rr    lr
        tbl[0]  = '{1'b1, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 8'h00, 1'b0, 8'h15, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 8'hC5, 1'b0, 8'h01, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[3]  = '{1'b0, 8'h40, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 8'h81, 1'b0, 8'h22, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 8'hC7, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 8'hC8, 1'b0, 8'h23, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 8'hC8, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 8'h50, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 8'h51, 1'b0, 8'h30, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 8'h51, 1'b0, 8'h30, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 8'h00, 1'b0, 8'h30, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[12] = '{1'b1, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};

        // Reset held with both FIFOs non-empty.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 8'hC1, 1'b0, 8'h11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            chk("rst_out_vld", 32'(oOutVld), 32'd0);
            chk("rst_ej_vld", 32'(oEjVld), 32'd0);
        end

        // Table: local-only, eject+inject, head-of-line block, out backpressure.
        for (int i = 0; i < 13; i++) begin
            step(1'b0, tbl[i].re, tbl[i].rd, tbl[i].le, tbl[i].ld, tbl[i].ordy,
                 tbl[i].erdy, tbl[i].rr, tbl[i].lr, 1'b0);
        end

        // Starvation: four ring wins, forced local, then ring again.
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, flit_t'(8'h40 + i), 1'b0, 8'h2A, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        step(1'b0, 1'b0, 8'h44, 1'b0, 8'h2A, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 8'h44, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

        // Backpressure: 0x41 held five cycles while 0xC0 still ejects.
        step(1'b0, 1'b0, 8'h41, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'hC0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("bp_out_dat", 32'(oOutDat), 32'h41);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 8'h42, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            chk("bp_out_dat", 32'(oOutDat), 32'h41);
            chk("bp_out_vld", 32'(oOutVld), 32'd1);
        end
        step(1'b0, 1'b0, 8'h42, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

        // Reset while forced: state and both slots clear, counter restarts.
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, flit_t'(8'h43 + i), 1'b0, 8'h2A, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        step(1'b1, 1'b0, 8'h47, 1'b0, 8'h2A, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        out_q.delete();
        ej_q.delete();
        step(1'b0, 1'b0, 8'h60, 1'b0, 8'h2B, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("post_rst_out_vld", 32'(oOutVld), 32'd0);
        chk("post_rst_ej_vld", 32'(oEjVld), 32'd0);
        for (int i = 1; i < 4; i++) begin
            step(1'b0, 1'b0, flit_t'(8'h60 + i), 1'b0, 8'h2B, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        step(1'b0, 1'b0, 8'h64, 1'b0, 8'h2B, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);

        // Drain and confirm every expected flit came out.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        chk("out_q_empty", 32'(out_q.size()), 32'd0);
        chk("ej_q_empty", 32'(ej_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
